bfloat_mul_pipe: RTL and testbench
==================================

# bfloat_mul_pipe

Pipelined bfloat16 multiplier that forms the product half of the mac1 datapath; its output feeds the bfloat16 add/sub stage that accumulates products. It accepts operand pairs through a valid/ready handshake, computes a·b with round-to-nearest-even, and presents results in order through a second valid/ready handshake. Subnormals are flushed to zero; Inf/NaN are handled explicitly.

## Interface
- No parameters; format fixed at bfloat16: sign [15], exponent [14:7], mantissa [6:0], bias 127.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  stage 1 can accept this cycle
- a  in  16  operand A, bfloat16
- b  in  16  operand B, bfloat16
- out_valid  out  1  product present on p
- out_ready  in  1  consumer accepts p this cycle
- p  out  16  product, bfloat16
- flags  out  4  {nan, ovf, unf, zero}; present only with BFLOAT_MUL_FLAGS_EN

## Operation
- Transfer occurs on a rising edge with valid && ready high; no other condition moves data.
- Stage 1 (unpack/multiply): sign = a[15]^b[15]. Significands {1,m} are 8 bits each; their product is 16 bits. Exponent sum is ea+eb-127 in 10-bit signed. Stage 1 also classifies each operand as zero (exp==0, any mantissa), inf (exp==255, mant==0), or nan (exp==255, mant!=0).
- Stage 2 (normalize/round):
  - If prod[15]==1: kept = prod[14:8], g = prod[8], r = prod[7], s = |prod[6:0], exp += 1.
  - Otherwise: kept = prod[13:7], g = prod[7], r = prod[6], s = |prod[5:0].
  - Round up iff r && (g || s). This is RNE and matches the adder's rule.
  - If rounding carries out of the mantissa: mantissa = 0, exp += 1.
- Stage 3: result register driving p and flags.
- Special results, in priority order:
  - Any nan, or inf × zero: 16'h7FC0.
  - Inf × nonzero: {sign, 8'hFF, 7'h0}.
  - Zero operand: {sign, 15'h0}.
  - Final exp ≥ 255 (overflow): {sign, 8'hFF, 7'h0}.
  - Final exp ≤ 0 (underflow): {sign, 15'h0}.
- Flags (when enabled) are registered alongside p.
  - nan: NaN output.
  - ovf: overflow to inf.
  - unf: underflow flush.
  - zero: output is ±0 for any reason.

## Timing
- Latency is 3 cycles from input accept to out_valid with no stall. Throughput is 1 product per cycle.
- Each stage k holds a valid bit vk. Stage k loads when its input is valid and (!vk || stage k+1 loads). Stage 3 advances when out_ready || !v3.
- in_ready = !v1 || stage 2 loads. It is combinational from out_ready through the valid chain, so bubbles collapse.
- With out_ready held low, the pipe fills 3 deep and in_ready goes low. Data in all stages is held stable.
- p and flags stay constant while out_valid && !out_ready.
- Simultaneous accept at the input and emit at the output with a full pipe sustains full throughput, with no bubble.
- Reset (asynchronous, any time, including mid-stream):
  - v1..v3 = 0, out_valid = 0, p = 16'h0000, flags = 4'h0.
  - in_ready = 1 in the first cycle after deassertion.
  - In-flight data is discarded.
- Datapath registers other than p and flags need no reset.

## Configuration
- BFLOAT_MUL_FLAGS_EN defined: the flags port exists and a 4-bit flag field is carried through stages 2–3.
- Not defined: no flags port and no flag registers; p is bit-identical in both builds.

## Structure
- Package bfloat_pkg holds:
  - typedef struct packed bf16_t {sign, exp[7:0], mant[6:0]};
  - localparams BF_BIAS=127, BF_EXP_MAX=255, BF_QNAN=16'h7FC0;
  - flag bit index constants.
- bfloat_add_sub imports the same package later.
- One sub-module: bfloat_norm_round. It is combinational and maps {prod[15:0], exp[9:0]} to {mant[6:0], exp[9:0]} as in stage 2, and the adder will reuse it.

## Test plan
- 1.5 × 2.0: a=16'h3FC0, b=16'h4000 -> p=16'h4040 at 3 cycles after accept, out_ready=1.
- Sign and round-down: 16'h3F80 × 16'hBF80 -> 16'hBF80. 16'h3F81 × 16'h3F81 -> 16'h3F82. 16'h3FFF × 16'h3FFF -> 16'h407E.
- Specials:
  - 16'h7F00 × 16'h7F00 -> 16'h7F80 (ovf).
  - 16'h0080 × 16'h0080 -> 16'h0000 (unf).
  - 16'h7F80 × 16'h0000 -> 16'h7FC0 (nan).
  - 16'h8000 × 16'h4000 -> 16'h8000 (zero).
- Backpressure: out_ready=0, offer 4 pairs back-to-back. Exactly 3 are accepted and in_ready falls. p holds the first result. Raising out_ready drains all 4 in order with no loss or duplication.
- Streaming: 100 random operand pairs with in_valid=1 and random out_ready. Results match a reference model with FTZ and RNE, in order.
- Reset mid-stream: assert rst_n=0 with the pipe full. out_valid=0 and p=16'h0000 immediately. After release, no stale result appears and the first new result emerges 3 cycles after accept.

Source files
------------

// File: rtl/bfloat_pkg.sv
// Shared bfloat16 definitions for the mac1 multiply and add/sub datapaths.
package bfloat_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    localparam logic [9:0]  BF_BIAS    = 10'd127;
    localparam logic [9:0]  BF_EXP_MAX = 10'd255;
    localparam logic [15:0] BF_QNAN    = 16'h7FC0;

    // Bit positions within the {nan, ovf, unf, zero} flag field
    localparam int FLAG_NAN  = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/bfloat_norm_round.sv
// Normalizes a 16-bit significand product and rounds it to 7 mantissa bits (RNE).
// Combinational; shared with the bfloat16 add/sub stage.
module bfloat_norm_round (
    input  logic [15:0] i_prod,
    input  logic [9:0]  i_exp,
    output logic [6:0]  o_mant,
    output logic [9:0]  o_exp
);

    logic       w_hi;
    logic       w_g;
    logic       w_r;
    logic       w_s;
    logic       w_up;
    logic [6:0] w_kept;
    logic [7:0] w_sum;
    logic [9:0] w_exp_n;

    // w_g is the LSB that survives; w_r the first dropped bit; w_s the sticky OR below it
    assign w_hi   = i_prod[15];
    assign w_kept = w_hi ? i_prod[14:8] : i_prod[13:7];
    assign w_g    = w_hi ? i_prod[8]    : i_prod[7];
    assign w_r    = w_hi ? i_prod[7]    : i_prod[6];
    assign w_s    = w_hi ? (|i_prod[6:0]) : (|i_prod[5:0]);
    assign w_up   = w_r && (w_g || w_s);

    assign w_sum   = {1'b0, w_kept} + {7'd0, w_up};
    assign w_exp_n = i_exp + {9'd0, w_hi};

    // A carry out of the mantissa leaves it at zero and bumps the exponent
    assign o_mant = w_sum[6:0];
    assign o_exp  = w_exp_n + {9'd0, w_sum[7]};

endmodule

// File: rtl/bfloat_mul_pipe.sv
// Three-stage bfloat16 multiplier (unpack/multiply, normalize/round, result) with
// valid/ready on both sides. Define BFLOAT_MUL_FLAGS_EN to add the flags port.
module bfloat_mul_pipe
    import bfloat_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p
`ifdef BFLOAT_MUL_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    bf16_t w_a;
    bf16_t w_b;
    assign w_a = a;
    assign w_b = b;

    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic w_ld1;
    logic w_ld2;
    logic w_ld3;

    // Load enables ripple back from the output so bubbles collapse in one cycle
    assign w_ld3    = r_v2 && (!r_v3 || out_ready);
    assign w_ld2    = r_v1 && (!r_v2 || w_ld3);
    assign in_ready = !r_v1 || w_ld2;
    assign w_ld1    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_ld1)
                r_v1 <= 1'b1;
            else if (w_ld2)
                r_v1 <= 1'b0;
            if (w_ld2)
                r_v2 <= 1'b1;
            else if (w_ld3)
                r_v2 <= 1'b0;
            if (w_ld3)
                r_v3 <= 1'b1;
            else if (out_ready)
                r_v3 <= 1'b0;
        end
    end

    logic               w_zero_a;
    logic               w_zero_b;
    logic               w_inf_a;
    logic               w_inf_b;
    logic               w_nan_a;
    logic               w_nan_b;
    logic        [15:0] w_prod;
    logic signed [9:0]  w_exp_sum;

    assign w_zero_a  = (w_a.exp == 8'd0);
    assign w_zero_b  = (w_b.exp == 8'd0);
    assign w_inf_a   = (w_a.exp == 8'hFF) && (w_a.mant == 7'd0);
    assign w_inf_b   = (w_b.exp == 8'hFF) && (w_b.mant == 7'd0);
    assign w_nan_a   = (w_a.exp == 8'hFF) && (w_a.mant != 7'd0);
    assign w_nan_b   = (w_b.exp == 8'hFF) && (w_b.mant != 7'd0);
    assign w_prod    = {8'd0, 1'b1, w_a.mant} * {8'd0, 1'b1, w_b.mant};
    assign w_exp_sum = {2'b00, w_a.exp} + {2'b00, w_b.exp} - BF_BIAS;

    logic               r1_sign;
    logic        [15:0] r1_prod;
    logic signed [9:0]  r1_exp;
    logic               r1_nan;
    logic               r1_inf;
    logic               r1_zero;

    always_ff @(posedge clk) begin
        if (w_ld1) begin
            r1_sign <= w_a.sign ^ w_b.sign;
            r1_prod <= w_prod;
            r1_exp  <= w_exp_sum;
            r1_nan  <= w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);
            r1_inf  <= w_inf_a || w_inf_b;
            r1_zero <= w_zero_a || w_zero_b;
        end
    end

    logic        [6:0]  w_nr_mant;
    logic signed [9:0]  w_nr_exp;
    logic               w_ovf;
    logic               w_unf;
    logic        [15:0] w_p2;

    bfloat_norm_round u_norm_round (
        .i_prod (r1_prod),
        .i_exp  (r1_exp),
        .o_mant (w_nr_mant),
        .o_exp  (w_nr_exp)
    );

    assign w_ovf = !r1_nan && !r1_inf && !r1_zero && (w_nr_exp >= $signed(BF_EXP_MAX));
    assign w_unf = !r1_nan && !r1_inf && !r1_zero && (w_nr_exp <= 10'sd0);

    always_comb begin
        w_p2 = {r1_sign, w_nr_exp[7:0], w_nr_mant};
        if (r1_nan)
            w_p2 = BF_QNAN;
        else if (r1_inf || w_ovf)
            w_p2 = {r1_sign, 8'hFF, 7'h0};
        else if (r1_zero || w_unf)
            w_p2 = {r1_sign, 15'h0};
    end

    logic [15:0] r2_p;
    logic [15:0] r_p;

    always_ff @(posedge clk) begin
        if (w_ld2)
            r2_p <= w_p2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_p <= 16'h0000;
        else if (w_ld3)
            r_p <= r2_p;
    end

    assign p         = r_p;
    assign out_valid = r_v3;

`ifdef BFLOAT_MUL_FLAGS_EN
    logic [3:0] w_flags2;
    logic [3:0] r2_flags;
    logic [3:0] r_flags;

    always_comb begin
        w_flags2            = 4'h0;
        w_flags2[FLAG_NAN]  = r1_nan;
        w_flags2[FLAG_OVF]  = w_ovf;
        w_flags2[FLAG_UNF]  = w_unf;
        w_flags2[FLAG_ZERO] = (w_p2[14:0] == 15'd0);
    end

    always_ff @(posedge clk) begin
        if (w_ld2)
            r2_flags <= w_flags2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flags <= 4'h0;
        else if (w_ld3)
            r_flags <= r2_flags;
    end

    assign flags = r_flags;
`endif

endmodule

// File: tb/tb_bfloat_mul_pipe.sv
// Self-checking bench for bfloat_mul_pipe: directed vectors, backpressure,
// streaming against a reference model, and reset mid-stream.
module tb_bfloat_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
`ifdef BFLOAT_MUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bfloat_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
`ifdef BFLOAT_MUL_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer product rounded by remainder comparison, FTZ, specials first
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic s;
        int ex, ey, e, prod, sh, kept, rem, half;
        logic xz, yz, xi, yi, xn, yn;
        s  = x[15] ^ y[15];
        ex = int'(x[14:7]);
        ey = int'(y[14:7]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[6:0] == 7'd0);
        yi = (ey == 255) && (y[6:0] == 7'd0);
        xn = (ex == 255) && (x[6:0] != 7'd0);
        yn = (ey == 255) && (y[6:0] != 7'd0);
        if (xn || yn || (xi && yz) || (yi && xz)) return 16'h7FC0;
        if (xi || yi) return {s, 8'hFF, 7'h0};
        if (xz || yz) return {s, 15'h0};
        prod = (128 + int'(x[6:0])) * (128 + int'(y[6:0]));
        if (prod >= 32768) begin
            sh = 8;
            e  = ex + ey - 126;
        end else begin
            sh = 7;
            e  = ex + ey - 127;
        end
        kept = prod >> sh;
        rem  = prod % (1 << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (kept % 2) == 1)) kept = kept + 1;
        if (kept == 256) begin
            kept = 128;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 7'h0};
        if (e <= 0) return {s, 15'h0};
        return {s, e[7:0], kept[6:0]};
    endfunction

    function automatic logic [15:0] rand_op(input int i);
        logic [7:0] e;
        e = 8'($urandom_range(60, 194));
        if (i % 17 == 5) e = 8'h00;
        if (i % 23 == 7) e = 8'hFF;
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_checks++;
        if (p !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_p got=%h want=0000", p);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        $display("reset: out_valid=%b p=%h in_ready=%b", out_valid, p, in_ready);
    endtask

    task automatic test_products();
        logic [15:0] ta[4], tb[4], te[4];
        logic [3:0]  tf[4];
        int lat;
        ta = '{16'h3FC0, 16'h3F80, 16'h3F81, 16'h3FFF};
        tb = '{16'h4000, 16'hBF80, 16'h3F81, 16'h3FFF};
        te = '{16'h4040, 16'hBF80, 16'h3F82, 16'h407E};
        tf = '{4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = ta[i]; b = tb[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat !== 3) begin
                n_fail++;
                $display("FAIL prod_latency[%0d] got=%0d want=3", i, lat);
            end
            n_checks++;
            if (p !== te[i]) begin
                n_fail++;
                $display("FAIL prod_p[%0d] a=%h b=%h got=%h want=%h", i, ta[i], tb[i], p, te[i]);
            end
`ifdef BFLOAT_MUL_FLAGS_EN
            n_checks++;
            if (flags !== tf[i]) begin
                n_fail++;
                $display("FAIL prod_flags[%0d] got=%b want=%b", i, flags, tf[i]);
            end
`endif
            $display("product: %h x %h -> %h (latency %0d)", ta[i], tb[i], p, lat);
        end
    endtask

    task automatic test_specials();
        logic [15:0] ta[4], tb[4], te[4];
        logic [3:0]  tf[4];
        int lat;
        ta = '{16'h7F00, 16'h0080, 16'h7F80, 16'h8000};
        tb = '{16'h7F00, 16'h0080, 16'h0000, 16'h4000};
        te = '{16'h7F80, 16'h0000, 16'h7FC0, 16'h8000};
        tf = '{4'b0100, 4'b0011, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = ta[i]; b = tb[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat !== 3) begin
                n_fail++;
                $display("FAIL special_latency[%0d] got=%0d want=3", i, lat);
            end
            n_checks++;
            if (p !== te[i]) begin
                n_fail++;
                $display("FAIL special_p[%0d] a=%h b=%h got=%h want=%h", i, ta[i], tb[i], p, te[i]);
            end
`ifdef BFLOAT_MUL_FLAGS_EN
            n_checks++;
            if (flags !== tf[i]) begin
                n_fail++;
                $display("FAIL special_flags[%0d] got=%b want=%b", i, flags, tf[i]);
            end
`endif
            $display("special: %h x %h -> %h expect %h flags %b", ta[i], tb[i], p, te[i], tf[i]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] want, cur;
        logic acc, emt;
        int sent, got, stalls, cyc;
        sent = 0; got = 0; stalls = 0; cyc = 0;
        while (got < 8 && cyc < 40) begin
            @(negedge clk);
            in_valid  = (sent < 8);
            a         = 16'h3F80 + 16'(sent * 37);
            b         = 16'h4010 - 16'(sent * 5);
            out_ready = 1'b1;
            #1;
            acc = in_valid && in_ready;
            emt = out_valid;
            cur = p;
            if (in_valid && !in_ready) stalls++;
            @(posedge clk);
            cyc++;
            if (acc) begin
                q.push_back(ref_mul(a, b));
                sent++;
            end
            if (emt) begin
                want = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                n_checks++;
                if (cur !== want) begin
                    n_fail++;
                    $display("FAIL b2b_p[%0d] got=%h want=%h", got, cur, want);
                end
                $display("b2b: result %0d = %h", got, cur);
                got++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (stalls !== 0) begin
            n_fail++;
            $display("FAIL b2b_stalls got=%0d want=0", stalls);
        end
        n_checks++;
        if (cyc !== 11) begin
            n_fail++;
            $display("FAIL b2b_cycles got=%0d want=11", cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ta[4], tb[4], te[4];
        logic [15:0] cur;
        logic acc, emt;
        int sent, got, cyc, extra;
        ta = '{16'h3FC0, 16'h3F80, 16'h3F81, 16'h3FFF};
        tb = '{16'h4000, 16'hBF80, 16'h3F81, 16'h3FFF};
        te = '{16'h4040, 16'hBF80, 16'h3F82, 16'h407E};
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (sent < 4);
            a = ta[sent % 4];
            b = tb[sent % 4];
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (sent !== 3) begin
            n_fail++;
            $display("FAIL bp_accepted got=%0d want=3", sent);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready got=%b want=0", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_out_valid got=%b want=1", out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (p !== te[0]) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got=%h want=%h", c, p, te[0]);
            end
            @(negedge clk);
        end
        $display("backpressure: accepted=%0d holding p=%h", sent, p);
        got = 0; cyc = 0;
        while (got < 4 && cyc < 30) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 4);
            a = ta[sent % 4];
            b = tb[sent % 4];
            #1;
            acc = in_valid && in_ready;
            emt = out_valid;
            cur = p;
            @(posedge clk);
            cyc++;
            if (acc) sent++;
            if (emt) begin
                n_checks++;
                if (cur !== te[got]) begin
                    n_fail++;
                    $display("FAIL bp_drain[%0d] got=%h want=%h", got, cur, te[got]);
                end
                $display("backpressure: drained %0d = %h", got, cur);
                got++;
            end
        end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) extra++;
        end
        n_checks++;
        if (got !== 4 || sent !== 4) begin
            n_fail++;
            $display("FAIL bp_count drained=%0d accepted=%0d want=4/4", got, sent);
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL bp_duplicate extra_valid_cycles=%0d want=0", extra);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] q[$];
        logic [15:0] cur_a, cur_b, want, cur;
        logic acc, emt;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        cur_a = rand_op(0);
        cur_b = rand_op(1);
        while (got < 100 && cyc < 2000) begin
            @(negedge clk);
            in_valid  = (sent < 100);
            a         = cur_a;
            b         = cur_b;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && in_ready;
            emt = out_valid && out_ready;
            cur = p;
            @(posedge clk);
            cyc++;
            if (acc) begin
                q.push_back(ref_mul(cur_a, cur_b));
                sent++;
                cur_a = rand_op(2 * sent);
                cur_b = rand_op(2 * sent + 1);
            end
            if (emt) begin
                want = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                n_checks++;
                if (cur !== want) begin
                    n_fail++;
                    $display("FAIL stream_p[%0d] got=%h want=%h", got, cur, want);
                end
                got++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (got !== 100) begin
            n_fail++;
            $display("FAIL stream_count got=%0d want=100 cycles=%0d", got, cyc);
        end
        $display("streaming: %0d results in %0d cycles", got, cyc);
    endtask

    task automatic test_reset_midstream();
        int lat, stale;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 16'h3FC0;
            b = 16'h4000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full got=%b want=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_out_valid got=%b want=0", out_valid);
        end
        n_checks++;
        if (p !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_rst_p got=%h want=0000", p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_in_ready got=%b want=1", in_ready);
        end
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL mid_stale got=%0d want=0", stale);
        end
        @(negedge clk);
        in_valid = 1'b1; a = 16'h3F81; b = 16'h3F81;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL mid_latency got=%0d want=3", lat);
        end
        n_checks++;
        if (p !== 16'h3F82) begin
            n_fail++;
            $display("FAIL mid_p got=%h want=3f82", p);
        end
        $display("reset mid-stream: first new result %h after %0d cycles", p, lat);
    endtask

    initial begin
        test_reset();
        test_products();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_streaming();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
